// File: rtl/can_decoder.sv
// CAN 2.0A/2.0B receive decoder: destuffs sampled bus bits, parses the frame, checks CRC-15 and form.
// Fields and error_out are registered and update one clock after each detected sample strobe edge.
module can_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_bit,
  input  logic        sample_point,
  input  logic        error_in,
  output logic        error_out,
  output logic        field_start_of_frame,
  output logic [10:0] field_id_a,
  output logic        field_ide,
  output logic        field_rtr,
  output logic        field_srr,
  output logic        field_reserved1,
  output logic        field_reserved0,
  output logic [17:0] field_id_b,
  output logic [3:0]  field_dlc,
  output logic [63:0] field_data,
  output logic [14:0] field_crc,
  output logic        field_crc_delimiter,
  output logic        field_ack_slot
);

  typedef enum logic [3:0] {
    S_IDLE, S_ID_A, S_RTR_SRR, S_IDE, S_ID_B, S_RTR, S_R1, S_R0, S_DLC,
    S_DATA, S_CRC, S_CRC_DELIM, S_ACK_SLOT, S_ACK_DELIM, S_EOF, S_WAIT_IDLE
  } state_t;

  state_t      state;
  logic        sp_q;
  logic [6:0]  cnt;
  logic        last_bit;
  logic [2:0]  run_len;
  logic        rtr_srr;
  logic [14:0] crc_reg;

  logic        sample;
  logic        crc_zone;
  logic        stuff_zone;
  logic        stuff_bit;
  logic        stuff_err;
  logic        proto_err;
  logic [14:0] crc_next;
  logic [3:0]  dlc_next;
  logic [3:0]  data_bytes;
  logic [6:0]  data_bits;

  always_comb begin
    sample     = sample_point & ~sp_q;
    crc_zone   = state inside {S_ID_A, S_RTR_SRR, S_IDE, S_ID_B, S_RTR, S_R1, S_R0, S_DLC, S_DATA};
    // The bit following the last CRC bit can still be a stuff bit, hence CRC_DELIM is included.
    stuff_zone = crc_zone || state == S_CRC || state == S_CRC_DELIM;
    stuff_bit  = stuff_zone && run_len == 3'd5;
    stuff_err  = stuff_bit && rx_bit == last_bit;
    proto_err  = stuff_err ||
                 (!stuff_bit && state inside {S_CRC_DELIM, S_ACK_DELIM, S_EOF} && !rx_bit) ||
                 (!stuff_bit && state == S_CRC_DELIM && field_crc != crc_reg);
    crc_next   = {crc_reg[13:0], 1'b0} ^ ((rx_bit ^ crc_reg[14]) ? 15'h4599 : 15'h0000);
    dlc_next   = {field_dlc[2:0], rx_bit};
    data_bytes = 4'd0;
    if (!field_rtr) data_bytes = (dlc_next > 4'd8) ? 4'd8 : dlc_next;
    data_bits  = {data_bytes, 3'b000};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      sp_q                 <= 1'b0;
      cnt                  <= '0;
      last_bit             <= 1'b0;
      run_len              <= '0;
      rtr_srr              <= 1'b0;
      crc_reg              <= '0;
      error_out            <= 1'b0;
      field_start_of_frame <= 1'b0;
      field_id_a           <= '0;
      field_ide            <= 1'b0;
      field_rtr            <= 1'b0;
      field_srr            <= 1'b0;
      field_reserved1      <= 1'b0;
      field_reserved0      <= 1'b0;
      field_id_b           <= '0;
      field_dlc            <= '0;
      field_data           <= '0;
      field_crc            <= '0;
      field_crc_delimiter  <= 1'b0;
      field_ack_slot       <= 1'b0;
    end else begin
      sp_q <= sample_point;
      if (error_in) begin
        state <= S_WAIT_IDLE;
        cnt   <= '0;
      end else if (sample) begin
        if (stuff_zone) begin
          if (stuff_bit || rx_bit != last_bit) begin
            last_bit <= rx_bit;
            run_len  <= 3'd1;
          end else begin
            run_len <= run_len + 3'd1;
          end
        end
        if (proto_err) begin
          error_out <= 1'b1;
          state     <= S_WAIT_IDLE;
          cnt       <= '0;
        end else if (!stuff_bit) begin
          if (crc_zone) crc_reg <= crc_next;
          case (state)
            S_IDLE: if (!rx_bit) begin
              field_start_of_frame <= 1'b0;
              field_data           <= '0;
              field_id_b           <= '0;
              field_srr            <= 1'b0;
              field_reserved1      <= 1'b0;
              crc_reg              <= '0;
              last_bit             <= 1'b0;
              run_len              <= 3'd1;
              cnt                  <= '0;
              state                <= S_ID_A;
            end
            S_ID_A: begin
              field_id_a <= {field_id_a[9:0], rx_bit};
              if (cnt == 7'd10) begin cnt <= '0; state <= S_RTR_SRR; end
              else cnt <= cnt + 7'd1;
            end
            S_RTR_SRR: begin rtr_srr <= rx_bit; state <= S_IDE; end
            S_IDE: begin
              field_ide <= rx_bit;
              if (rx_bit) begin field_srr <= rtr_srr; cnt <= '0; state <= S_ID_B; end
              else begin field_rtr <= rtr_srr; state <= S_R0; end
            end
            S_ID_B: begin
              field_id_b <= {field_id_b[16:0], rx_bit};
              if (cnt == 7'd17) begin cnt <= '0; state <= S_RTR; end
              else cnt <= cnt + 7'd1;
            end
            S_RTR: begin field_rtr <= rx_bit; state <= S_R1; end
            S_R1: begin field_reserved1 <= rx_bit; state <= S_R0; end
            S_R0: begin field_reserved0 <= rx_bit; cnt <= '0; state <= S_DLC; end
            S_DLC: begin
              field_dlc <= dlc_next;
              if (cnt == 7'd3) begin
                if (data_bits == 7'd0) begin cnt <= '0; state <= S_CRC; end
                else begin cnt <= data_bits - 7'd1; state <= S_DATA; end
              end else cnt <= cnt + 7'd1;
            end
            S_DATA: begin
              field_data <= {field_data[62:0], rx_bit};
              if (cnt == 7'd0) state <= S_CRC;
              else cnt <= cnt - 7'd1;
            end
            S_CRC: begin
              field_crc <= {field_crc[13:0], rx_bit};
              if (cnt == 7'd14) begin cnt <= '0; state <= S_CRC_DELIM; end
              else cnt <= cnt + 7'd1;
            end
            S_CRC_DELIM: begin field_crc_delimiter <= rx_bit; state <= S_ACK_SLOT; end
            S_ACK_SLOT: begin field_ack_slot <= rx_bit; state <= S_ACK_DELIM; end
            S_ACK_DELIM: begin cnt <= '0; state <= S_EOF; end
            S_EOF: begin
              if (cnt == 7'd6) begin cnt <= '0; state <= S_IDLE; end
              else cnt <= cnt + 7'd1;
            end
            S_WAIT_IDLE: begin
              // Eleven consecutive recessive samples mark the bus as idle again.
              if (!rx_bit) cnt <= '0;
              else if (cnt == 7'd10) begin cnt <= '0; error_out <= 1'b0; state <= S_IDLE; end
              else cnt <= cnt + 7'd1;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_can_decoder.sv
// Directed bench for can_decoder: frames are serialised with a bit-level generator and checked against a queue of expected fields.
module tb_can_decoder;
  logic        clock = 1'b0;
  logic        reset, rx_bit, sample_point, error_in;
  logic        error_out, field_start_of_frame, field_ide, field_rtr, field_srr;
  logic        field_reserved1, field_reserved0, field_crc_delimiter, field_ack_slot;
  logic [10:0] field_id_a;
  logic [17:0] field_id_b;
  logic [3:0]  field_dlc;
  logic [63:0] field_data;
  logic [14:0] field_crc;

  can_decoder dut (
    .clock(clock), .reset(reset), .rx_bit(rx_bit), .sample_point(sample_point), .error_in(error_in),
    .error_out(error_out), .field_start_of_frame(field_start_of_frame), .field_id_a(field_id_a),
    .field_ide(field_ide), .field_rtr(field_rtr), .field_srr(field_srr),
    .field_reserved1(field_reserved1), .field_reserved0(field_reserved0), .field_id_b(field_id_b),
    .field_dlc(field_dlc), .field_data(field_data), .field_crc(field_crc),
    .field_crc_delimiter(field_crc_delimiter), .field_ack_slot(field_ack_slot)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [10:0] id_a;
    logic        ide, rtr, srr, r1, r0;
    logic [17:0] id_b;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [14:0] crc;
  } exp_t;

  exp_t  sb[$];
  bit    stream[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string ref_str = "110000010010100000100010000010011110111010100111011111111111";

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit per six clocks; returns on a falling edge after the DUT has registered the sample.
  task automatic send_bit(input bit b);
    @(negedge clock);
    rx_bit = b;
    sample_point = 1'b1;
    @(negedge clock);
    sample_point = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i <= to; i++) send_bit(stream[i]);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic load_reference();
    stream.delete();
    for (int i = 0; i < ref_str.len(); i++) stream.push_back(ref_str[i] == 8'h31);
  endtask

  task automatic push_reference_exp();
    exp_t e;
    e.id_a = 11'h014; e.ide = 0; e.rtr = 0; e.srr = 0; e.r1 = 0; e.r0 = 0;
    e.id_b = 0; e.dlc = 4'd1; e.data = 64'h01; e.crc = 15'h7753;
    sb.push_back(e);
  endtask

  task automatic build_frame(input logic ide, input logic [10:0] id_a, input logic [17:0] id_b,
                             input logic rtr, input logic [3:0] dlc, input logic [63:0] data);
    bit          raw[$];
    exp_t        e;
    int          nbytes, run;
    bit          last;
    logic [14:0] crc;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id_a[i]);
    if (ide) begin
      raw.push_back(1'b1);
      raw.push_back(1'b1);
      for (int i = 17; i >= 0; i--) raw.push_back(id_b[i]);
      raw.push_back(rtr);
      raw.push_back(1'b0);
      raw.push_back(1'b0);
    end else begin
      raw.push_back(rtr);
      raw.push_back(1'b0);
      raw.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = nbytes * 8 - 1; i >= 0; i--) raw.push_back(data[i]);
    crc = '0;
    foreach (raw[i]) begin
      if (raw[i] ^ crc[14]) crc = {crc[13:0], 1'b0} ^ 15'h4599;
      else crc = {crc[13:0], 1'b0};
    end
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    stream.delete();
    stream.push_back(1'b1);
    stream.push_back(1'b1);
    last = 1'b0;
    run = 0;
    foreach (raw[i]) begin
      stream.push_back(raw[i]);
      if (i > 0 && raw[i] == last) run++;
      else begin last = raw[i]; run = 1; end
      if (run == 5) begin stream.push_back(!last); last = !last; run = 1; end
    end
    stream.push_back(1'b1);
    stream.push_back(1'b0);
    stream.push_back(1'b1);
    for (int i = 0; i < 10; i++) stream.push_back(1'b1);
    e.id_a = id_a; e.ide = ide; e.rtr = rtr; e.srr = ide; e.r1 = 0; e.r0 = 0;
    e.id_b = ide ? id_b : 18'h0; e.dlc = dlc; e.crc = crc;
    e.data = (nbytes == 8) ? data : (data & ((64'd1 << (nbytes * 8)) - 64'd1));
    sb.push_back(e);
  endtask

  task automatic compare_frame(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed frame output, expected scoreboard entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "/error_out"}, 128'(error_out), 128'(1'b0));
      check({tag, "/sof"},       128'(field_start_of_frame), 128'(1'b0));
      check({tag, "/id_a"},      128'(field_id_a), 128'(e.id_a));
      check({tag, "/ide"},       128'(field_ide), 128'(e.ide));
      check({tag, "/rtr"},       128'(field_rtr), 128'(e.rtr));
      check({tag, "/srr"},       128'(field_srr), 128'(e.srr));
      check({tag, "/r1"},        128'(field_reserved1), 128'(e.r1));
      check({tag, "/r0"},        128'(field_reserved0), 128'(e.r0));
      check({tag, "/id_b"},      128'(field_id_b), 128'(e.id_b));
      check({tag, "/dlc"},       128'(field_dlc), 128'(e.dlc));
      check({tag, "/data"},      128'(field_data), 128'(e.data));
      check({tag, "/crc"},       128'(field_crc), 128'(e.crc));
      check({tag, "/crc_delim"}, 128'(field_crc_delimiter), 128'(1'b1));
      check({tag, "/ack_slot"},  128'(field_ack_slot), 128'(1'b0));
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({error_out, field_start_of_frame, field_id_a, field_ide, field_rtr, field_srr,
                 field_reserved1, field_reserved0, field_id_b, field_dlc, field_data, field_crc,
                 field_crc_delimiter, field_ack_slot});
  endfunction

  initial begin
    reset = 1'b1;
    rx_bit = 1'b1;
    sample_point = 1'b0;
    error_in = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_state", all_outputs(), 128'(0));
    reset = 1'b0;

    // Reference standard frame with three stuff bits.
    load_reference();
    push_reference_exp();
    send_range(0, stream.size() - 1);
    compare_frame("std_ref");

    // Stuff bit at index 28 driven equal to the preceding run.
    load_reference();
    stream[28] = 1'b0;
    send_range(0, 27);
    check("stuff_pre", 128'(error_out), 128'(1'b0));
    send_range(28, 28);
    check("stuff_err", 128'(error_out), 128'(1'b1));
    check("stuff_keep_dlc", 128'(field_dlc), 128'(4'd1));
    check("stuff_keep_crc", 128'(field_crc), 128'(15'h7753));
    send_range(29, 58);
    check("stuff_hold_10", 128'(error_out), 128'(1'b1));
    send_range(59, 59);
    check("stuff_clear_11", 128'(error_out), 128'(1'b0));

    // Last CRC bit flipped.
    load_reference();
    stream[46] = 1'b0;
    send_range(0, 46);
    check("crc_pre_delim", 128'(error_out), 128'(1'b0));
    send_range(47, 47);
    check("crc_err", 128'(error_out), 128'(1'b1));
    check("crc_field", 128'(field_crc), 128'(15'h7752));
    send_range(48, 59);
    check("crc_clear", 128'(error_out), 128'(1'b0));

    // Extended remote frame: DLC=2 but no data bits on the wire.
    build_frame(1'b1, 11'h123, 18'h2A5C3, 1'b1, 4'd2, 64'hFFFF);
    send_range(0, stream.size() - 1);
    compare_frame("ext_remote");

    // Third EOF bit dominant.
    load_reference();
    stream[52] = 1'b0;
    send_range(0, 51);
    check("eof_pre", 128'(error_out), 128'(1'b0));
    send_range(52, 52);
    check("eof_form_err", 128'(error_out), 128'(1'b1));
    check("eof_keep_ack", 128'(field_ack_slot), 128'(1'b0));
    send_range(53, 59);
    idle_bits(11);
    check("eof_clear", 128'(error_out), 128'(1'b0));

    // External abort during DATA.
    load_reference();
    send_range(0, 25);
    error_in = 1'b1;
    @(negedge clock);
    error_in = 1'b0;
    send_range(26, 40);
    check("abort_mid", 128'(error_out), 128'(1'b0));
    send_range(41, 59);
    check("abort_end", 128'(error_out), 128'(1'b0));
    build_frame(1'b0, 11'h7A5, 18'h0, 1'b0, 4'd3, 64'hC35AF0);
    send_range(0, stream.size() - 1);
    compare_frame("after_abort");

    // DLC boundaries: zero bytes, and DLC above 8 clamped to eight bytes.
    build_frame(1'b0, 11'h000, 18'h0, 1'b0, 4'd0, 64'h0);
    send_range(0, stream.size() - 1);
    compare_frame("dlc0");
    build_frame(1'b0, 11'h555, 18'h0, 1'b0, 4'd9, 64'h0123456789ABCDEF);
    send_range(0, stream.size() - 1);
    compare_frame("dlc9");

    // Reset mid-frame, then the same frame decoded in full.
    build_frame(1'b0, 11'h3C1, 18'h0, 1'b0, 4'd8, 64'hDEADBEEF00112233);
    void'(sb.pop_back());
    send_range(0, 20);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_mid", all_outputs(), 128'(0));
    @(negedge clock);
    reset = 1'b0;
    build_frame(1'b0, 11'h3C1, 18'h0, 1'b0, 4'd8, 64'hDEADBEEF00112233);
    send_range(0, stream.size() - 1);
    compare_frame("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
